// File: rtl/lsu_mem_port.sv
// Load/store sequencer between the execute stage and a word-addressed data RAM.
// Optional WAIT-state timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_wdata,
  output logic              mem_en,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [1:0]          size_r, size_nxt_s;
  logic                uns_r, uns_nxt_s;
  logic [1:0]          lane_r, lane_nxt_s;
  logic                wr_r, wr_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [3:0]          mem_sel_r, mem_sel_nxt_s;
  logic [31:0]         mem_wdata_r, mem_wdata_nxt_s;
  logic                mem_en_r, mem_en_nxt_s;
  logic                mem_write_r, mem_write_nxt_s;
  logic                resp_valid_r, resp_valid_nxt_s;
  logic                resp_err_r, resp_err_nxt_s;
  logic [31:0]         resp_rdata_r, resp_rdata_nxt_s;
  logic                unused_addr_s;

  assign unused_addr_s = ^req_addr[31:ADDR_W+2];

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
`else
  localparam int unused_timeout_p = TIMEOUT;
`endif

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = lane[0];
      2'b10:   is_bad = (lane != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_sel(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   store_sel = 4'b0001 << lane;
      2'b01:   store_sel = lane[1] ? 4'b1100 : 4'b0011;
      default: store_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   store_wdata = {4{wdata[7:0]}};
      2'b01:   store_wdata = {2{wdata[15:0]}};
      default: store_wdata = wdata;
    endcase
  endfunction

  // Lane shift first, then width select and extension
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   load_extract = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_extract = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s      = state_r;
    size_nxt_s       = size_r;
    uns_nxt_s        = uns_r;
    lane_nxt_s       = lane_r;
    wr_nxt_s         = wr_r;
    mem_addr_nxt_s   = mem_addr_r;
    mem_sel_nxt_s    = mem_sel_r;
    mem_wdata_nxt_s  = mem_wdata_r;
    mem_en_nxt_s     = 1'b0;
    mem_write_nxt_s  = mem_write_r;
    resp_valid_nxt_s = 1'b0;
    resp_err_nxt_s   = resp_err_r;
    resp_rdata_nxt_s = resp_rdata_r;
`ifdef LSU_TIMEOUT_EN
    cnt_nxt_s        = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (is_bad(req_size, req_addr[1:0])) begin
            state_nxt_s      = RESP;
            resp_valid_nxt_s = 1'b1;
            resp_err_nxt_s   = 1'b1;
            resp_rdata_nxt_s = 32'h0000_0000;
          end else begin
            state_nxt_s     = ISSUE;
            size_nxt_s      = req_size;
            uns_nxt_s       = req_unsigned;
            lane_nxt_s      = req_addr[1:0];
            wr_nxt_s        = req_write;
            mem_en_nxt_s    = 1'b1;
            mem_write_nxt_s = req_write;
            mem_addr_nxt_s  = req_addr[ADDR_W+1:2];
            mem_sel_nxt_s   = req_write ? store_sel(req_size, req_addr[1:0]) : 4'b1111;
            mem_wdata_nxt_s = req_write ? store_wdata(req_size, req_wdata) : 32'h0000_0000;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s     = WAIT;
        mem_write_nxt_s = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_nxt_s       = '0;
`endif
      end
      WAIT: begin
        if (mem_ack) begin
          state_nxt_s      = RESP;
          resp_valid_nxt_s = 1'b1;
          resp_err_nxt_s   = 1'b0;
          resp_rdata_nxt_s = wr_r ? 32'h0000_0000 : load_extract(mem_rdata, size_r, uns_r, lane_r);
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          state_nxt_s      = RESP;
          resp_valid_nxt_s = 1'b1;
          resp_err_nxt_s   = 1'b1;
          resp_rdata_nxt_s = 32'h0000_0000;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_nxt_s = WAIT;
        end
`endif
      end
      RESP: begin
        state_nxt_s    = IDLE;
        resp_err_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s     = IDLE;
        mem_write_nxt_s = 1'b0;
        resp_err_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, latched request fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      lane_r       <= 2'b00;
      wr_r         <= 1'b0;
      mem_addr_r   <= '0;
      mem_sel_r    <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      mem_en_r     <= 1'b0;
      mem_write_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      size_r       <= size_nxt_s;
      uns_r        <= uns_nxt_s;
      lane_r       <= lane_nxt_s;
      wr_r         <= wr_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_sel_r    <= mem_sel_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      mem_en_r     <= mem_en_nxt_s;
      mem_write_r  <= mem_write_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      resp_err_r   <= resp_err_nxt_s;
      resp_rdata_r <= resp_rdata_nxt_s;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // WAIT-state cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`endif

  assign req_ready  = (state_r == IDLE);
  assign mem_addr   = mem_addr_r;
  assign mem_sel    = mem_sel_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_en     = mem_en_r;
  assign mem_write  = mem_write_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store sequencer sitting directly upstream of the word-addressed data RAM.
- Takes byte-addressed load/store requests from the CPU execute stage and issues one single-cycle memory access per request.
- For stores: generates byte-lane selects and replicated write data. For loads: extracts the addressed lanes from the returned word and sign- or zero-extends them.
- Returns a one-cycle response pulse to the core.

Parameters:
- ADDR_W, 8: RAM word-address width; mem_addr = req_addr[ADDR_W+1:2], higher address bits ignored.
- TIMEOUT, 15: cycles to wait for mem_ack before error; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  block idle; request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size, or timeout.
- mem_addr  out  ADDR_W  word address to RAM.
- mem_sel  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_en  out  1  access strobe, exactly one cycle per access.
- mem_write  out  1  store qualifier.
- mem_rdata  in  32  RAM read word, valid in the mem_ack cycle.
- mem_ack  in  1  RAM completion; arrives the cycle after mem_en.

Behaviour:
- Reset (async, rst_n=0): state IDLE. resp_valid, resp_err, mem_en, mem_write = 0. mem_addr, mem_sel, mem_wdata, resp_rdata = 0.
- req_ready = (state==IDLE), so it reads 1 out of reset.
- All other outputs are registered.

State machine:
- IDLE, on accept, legal and aligned: latch size, unsigned flag and addr[1:0]; drive mem_* and set mem_en=1 on the next cycle; go ISSUE.
- IDLE, on accept, misaligned or size=11: no memory access; go RESP with err=1.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- ISSUE: mem_en drops to 0 after one cycle; go WAIT.
- WAIT: on mem_ack, capture the extracted data; go RESP.
- RESP: resp_valid=1 for one cycle; return to IDLE.
- Nominal latency: accept edge at cycle 0 -> mem_en in cycle 1 -> mem_ack in cycle 2 -> resp_valid in cycle 3.
- Throughput: one request per 4 cycles; req_ready=0 from ISSUE through RESP.

Store lanes:
- Byte: mem_sel = 1<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
- Half: mem_sel = 0011 (addr[1]=0) or 1100 (addr[1]=1); mem_wdata = {2{wdata[15:0]}}.
- Word: mem_sel = 1111; mem_wdata = wdata.
- Loads drive mem_sel = 1111 and mem_write = 0.

Load extraction:
- Shift mem_rdata right by addr[1:0]*8.
- Take 8 or 16 bits (byte/half), or all 32 (word).
- Extend to 32 bits per req_unsigned.

Boundary rules:
- Stores: resp_rdata=0.
- mem_ack while in IDLE, ISSUE or RESP: ignored, no state change.
- req_valid while req_ready=0: ignored; the request must be re-presented later.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A pending mem_ack after reset is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: a counter of width clog2(TIMEOUT+1) clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT without mem_ack, go RESP with resp_err=1 and resp_rdata=0. A late ack is ignored per the IDLE rule.
- Undefined: no counter; WAIT holds until mem_ack, indefinitely.

Test Plan:
- Store word addr 0x10, wdata 0xDEADBEEF -> cycle 1: mem_en=1, mem_write=1, mem_addr=0x04, mem_sel=1111, mem_wdata=0xDEADBEEF; cycle 3: resp_valid=1, resp_err=0.
- Store byte addr 0x13, wdata 0x000000A5 -> mem_sel=1000, mem_wdata=0xA5A5A5A5; then load word 0x10 returns 0xA5ADBEEF.
- Load byte signed, addr 0x13, mem_rdata 0xA5ADBEEF -> resp_rdata=0xFFFFFFA5. Same with unsigned -> 0x000000A5.
- Load half signed, addr 0x12, mem_rdata 0x8001_0000 -> resp_rdata=0xFFFF8001. Half at addr 0x11 -> no mem_en; resp_valid one cycle after accept with resp_err=1.
- Assert rst_n=0 in WAIT -> all outputs 0 immediately; req_ready=1 after release; a stray mem_ack after release produces no resp_valid.
- LSU_TIMEOUT_EN, TIMEOUT=15, mem_ack withheld -> resp_valid with resp_err=1 exactly 15 cycles after entering WAIT; a later ack is ignored.
